multiplier: RTL
===============

// Module: multiplier
// PURPOSE
// - Sequential shift-add multiplier-accumulator: product = multiplicand*multiplier + addend, unsigned.
// - Inverse of the sequential divider: feeding it (quotient, divisor, remainder) rebuilds the dividend.
// - Same valid/busy/error handshake as the divider. Used for fixed-point scaling and divider self-check.
// PARAMETERS
// - WIDTH  32  operand and result width in bits. Legal range 2..64.
// PORTS
// - clk_in           in   1      system clock
// - rst_in           in   1      synchronous, active-high reset
// - multiplicand_in  in   WIDTH  operand A
// - multiplier_in    in   WIDTH  operand B
// - addend_in        in   WIDTH  operand C, added to A*B
// - data_valid_in    in   1      start request; sampled only in IDLE
// - product_out      out  WIDTH  low WIDTH bits of A*B+C
// - data_valid_out   out  1      one-cycle pulse; result valid
// - error_out        out  1      overflow: A*B+C >= 2**WIDTH
// - busy_out         out  1      high while an operation is in flight
// - Reset and clock are one clock domain: one clock; reset is synchronous and active-high (clk_in, rst_in).
// BEHAVIOUR
// - Reset: state=IDLE; count=0; all internal registers=0.
//   - product_out=0, data_valid_out=0, error_out=0, busy_out=0.
//   - rst_in has priority at every edge; reset mid-operation discards the operation and no data_valid_out pulse follows.
// - States: IDLE, MULTIPLYING.
// - IDLE, data_valid_in=1 at edge k:
//   - acc(2*WIDTH) = zero-extended C; mcand(2*WIDTH) = zero-extended A; mplier = B.
//   - count = WIDTH-1; busy_out=1; data_valid_out=0; error_out=0; go to MULTIPLYING.
// - IDLE, data_valid_in=0: data_valid_out=0; all else holds.
// - MULTIPLYING, each edge:
//   - if mplier[0], acc += mcand; then mcand <<= 1; mplier >>= 1; count -= 1.
// - MULTIPLYING, count==0 edge (edge k+WIDTH), performs the final step and:
//   - product_out = acc_next[WIDTH-1:0].
//   - error_out = |acc_next[2*WIDTH-1:WIDTH].
//   - data_valid_out=1; busy_out=0; go to IDLE.
// - Latency: fixed WIDTH cycles from the accepting edge to the data_valid_out edge. No zero-operand early exit.
// - data_valid_in while busy_out=1 is ignored (not queued).
// - Back-to-back: a request in the cycle data_valid_out=1 is accepted (state already IDLE).
// - Arithmetic: max A*B+C = 2**(2*WIDTH) - 2**WIDTH, so the 2*WIDTH-bit acc never wraps.
// - product_out and error_out hold until the next completion or reset. data_valid_out is never high for 2 consecutive cycles.
// - Counter width: $clog2(WIDTH).
// CONFIGURATION
// - HIGH_WORD_EN defined:
//   - adds port product_hi_out (out, WIDTH) = acc_next[2*WIDTH-1:WIDTH], registered with product_out.
//   - reset value 0; error_out still flags a nonzero high word.
// - HIGH_WORD_EN undefined: no product_hi_out port; the high word is used only to form error_out.
// STRUCTURE
// - Shared package arith_pkg:
//   - state enum typedef arith_state_t {IDLE, BUSY}, shared with the divider.
//   - localparam ARITH_WIDTH_DEFAULT = 32.
// - Single module; no sub-module. The datapath is one adder plus shifters.
// TESTING
// - A=7, B=6, C=0:
//   - product_out=42, error_out=0.
//   - data_valid_out high exactly WIDTH cycles after the accept edge.
//   - busy_out high for WIDTH cycles.
// - Round trip: divider 100/7 gives q=14, r=2; multiplier(14,7,2) -> product_out=100, error_out=0.
// - A=0x0001_0000, B=0x0001_0000, C=5 -> product_out=5, error_out=1, product_hi_out=1 (with macro).
// - A=B=C=0xFFFF_FFFF -> product_out=0x0000_0000, error_out=1, product_hi_out=0xFFFF_FFFF (with macro).
// - data_valid_in pulsed with A=3, B=3, C=0 mid-operation of A=2, B=5, C=1:
//   - a single result 11 is produced; the mid-operation request is dropped.
//   - a new request on the data_valid_out cycle is accepted and yields its result WIDTH cycles later.
// - rst_in for 1 cycle at iteration 10 -> all outputs 0 next cycle; no data_valid_out within 2*WIDTH cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: handshake state encoding and default width.
package arith_pkg;

   typedef enum logic {IDLE, BUSY} arith_state_t;

   localparam int unsigned ARITH_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/multiplier_if.sv
// Operand/result bus for the sequential multiplier-accumulator.
// Optional high-word output is present when HIGH_WORD_EN is defined.
interface multiplier_if
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = ARITH_WIDTH_DEFAULT
);
   logic [WIDTH-1:0] multiplicand_in;
   logic [WIDTH-1:0] multiplier_in;
   logic [WIDTH-1:0] addend_in;
   logic             data_valid_in;
   logic [WIDTH-1:0] product_out;
   logic             data_valid_out;
   logic             error_out;
   logic             busy_out;
`ifdef HIGH_WORD_EN
   logic [WIDTH-1:0] product_hi_out;
`endif

   modport master (
      output multiplicand_in, multiplier_in, addend_in, data_valid_in,
`ifdef HIGH_WORD_EN
      input  product_hi_out,
`endif
      input  product_out, data_valid_out, error_out, busy_out
   );

   modport slave (
      input  multiplicand_in, multiplier_in, addend_in, data_valid_in,
`ifdef HIGH_WORD_EN
      output product_hi_out,
`endif
      output product_out, data_valid_out, error_out, busy_out
   );
endinterface

// File: rtl/multiplier.sv
// Sequential shift-add multiplier-accumulator: product = A*B + C, unsigned, WIDTH cycles.
// Define HIGH_WORD_EN to expose the upper result word as product_hi_out.
module multiplier
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = ARITH_WIDTH_DEFAULT
) (
   input  logic        clk_in,
   input  logic        rst_in,
   multiplier_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   arith_state_t       state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      count;

   always_comb begin
      acc_next = mplier[0] ? acc + mcand : acc;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state              <= IDLE;
         acc                <= '0;
         mcand              <= '0;
         mplier             <= '0;
         count              <= '0;
         bus.product_out    <= '0;
         bus.data_valid_out <= 1'b0;
         bus.error_out      <= 1'b0;
         bus.busy_out       <= 1'b0;
`ifdef HIGH_WORD_EN
         bus.product_hi_out <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               bus.data_valid_out <= 1'b0;
               if (bus.data_valid_in) begin
                  acc          <= {{WIDTH{1'b0}}, bus.addend_in};
                  mcand        <= {{WIDTH{1'b0}}, bus.multiplicand_in};
                  mplier       <= bus.multiplier_in;
                  count        <= CW'(WIDTH - 1);
                  bus.busy_out <= 1'b1;
                  bus.error_out <= 1'b0;
                  state        <= BUSY;
               end
            end
            BUSY: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               count  <= count - 1'b1;
               // The last step publishes acc_next directly so latency stays exactly WIDTH.
               if (count == '0) begin
                  bus.product_out    <= acc_next[WIDTH-1:0];
                  bus.error_out      <= |acc_next[2*WIDTH-1:WIDTH];
`ifdef HIGH_WORD_EN
                  bus.product_hi_out <= acc_next[2*WIDTH-1:WIDTH];
`endif
                  bus.data_valid_out <= 1'b1;
                  bus.busy_out       <= 1'b0;
                  state              <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
